// File: rtl/mips_pipe_core.sv
// mips_pipe_core: five-stage (IF/ID/EX/MEM/WB) MIPS-style core with internal instruction/data memories.
// Latency: an instruction fetched at edge N commits writeback at edge N+4; halted rises one edge after HLT commits.
// Backpressure: load-use stalls (and, without forwarding, RAW stalls) hold PC and IF/ID; run low feeds bubbles.
// Optional feature macro: MIPS_FWD_EN enables EX operand forwarding from EX/MEM and MEM/WB.
module mips_pipe_core #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata,
  output logic                          halted,
  output logic [31:0]                   retired
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT  = 6'h04;
  localparam logic [5:0] OP_MUL  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h08;
  localparam logic [5:0] OP_SW   = 6'h09;
  localparam logic [5:0] OP_ADDI = 6'h0A;
  localparam logic [5:0] OP_SUBI = 6'h0B;
  localparam logic [5:0] OP_SLTI = 6'h0C;
  localparam logic [5:0] OP_BEQ  = 6'h0D;
  localparam logic [5:0] OP_BNE  = 6'h0E;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  // Pipeline registers; vld=0 marks a bubble, and reset clears every register to a bubble.
  typedef struct packed {
    logic            vld;
    logic [IAW-1:0]  pc;
    logic [31:0]     ir;
  } ifid_t;

  typedef struct packed {
    logic            vld;
    logic [5:0]      op;
`ifdef MIPS_FWD_EN
    logic [4:0]      rs;
    logic [4:0]      rt;
`endif
    logic [4:0]      dest;
    logic            we;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [IAW-1:0]  pc;
  } idex_t;

  typedef struct packed {
    logic            vld;
    logic            we;
    logic            is_lw;
    logic            is_sw;
    logic            hlt;
    logic [4:0]      dest;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
  } exmem_t;

  typedef struct packed {
    logic            vld;
    logic            we;
    logic            hlt;
    logic [4:0]      dest;
    logic [XLEN-1:0] val;
  } memwb_t;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] regs [32];

  logic [IAW-1:0] pc;
  logic           stopped;
  logic           halt_pend;
  ifid_t          ifid;
  idex_t          idex;
  exmem_t         exmem;
  memwb_t         memwb;

  // ID stage signals
  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_rd, id_dest;
  logic            id_is_r, id_is_i, id_use_rs, id_use_rt, id_we;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic            wb_wr, ex_hit, stall, hlt_id, fetch_en;

  // EX / MEM stage signals
  logic [XLEN-1:0] ex_a, ex_b, ex_alu, lmd;
  logic            br_taken;
  logic [IAW-1:0]  br_target;

  assign dbg_rdata = regs[dbg_raddr];
  assign wb_wr     = memwb.vld & memwb.we;
  assign fetch_en  = run & ~stopped & ~halted;
  assign lmd       = dmem[exmem.alu[DAW-1:0]];

  // Decode, write-first register read and hazard detection for the instruction in ID.
  always_comb begin
    id_op     = ifid.ir[31:26];
    id_rs     = ifid.ir[25:21];
    id_rt     = ifid.ir[20:16];
    id_rd     = ifid.ir[15:11];
    id_imm    = XLEN'($signed(ifid.ir[15:0]));
    id_is_r   = (id_op <= OP_MUL);
    id_is_i   = (id_op == OP_ADDI) | (id_op == OP_SUBI) | (id_op == OP_SLTI) | (id_op == OP_LW);
    id_dest   = id_is_r ? id_rd : id_rt;
    id_we     = (id_is_r | id_is_i) & (id_dest != 5'd0);
    id_use_rt = id_is_r | (id_op == OP_SW) | (id_op == OP_BEQ) | (id_op == OP_BNE);
    id_use_rs = id_use_rt | id_is_i;
    // R0 is never written, so regs[0] stays 0 and a WB dest never equals 0.
    id_a = regs[id_rs];
    if (wb_wr && memwb.dest == id_rs) id_a = memwb.val;
    id_b = regs[id_rt];
    if (wb_wr && memwb.dest == id_rt) id_b = memwb.val;
    ex_hit = idex.vld & idex.we &
             ((id_use_rs & (id_rs == idex.dest)) | (id_use_rt & (id_rt == idex.dest)));
`ifdef MIPS_FWD_EN
    stall = ifid.vld & ex_hit & (idex.op == OP_LW);
`else
    stall = ifid.vld & (ex_hit | (exmem.vld & exmem.we &
            ((id_use_rs & (id_rs == exmem.dest)) | (id_use_rt & (id_rt == exmem.dest)))));
`endif
    hlt_id = ifid.vld & (id_op == OP_HLT) & ~br_taken;
  end

  // EX operand selection, ALU and branch resolution.
  always_comb begin
    ex_a = idex.a;
    ex_b = idex.b;
`ifdef MIPS_FWD_EN
    // The newer producer (EX/MEM) wins over the older one (MEM/WB).
    if (exmem.vld && exmem.we && exmem.dest == idex.rs) ex_a = exmem.alu;
    else if (wb_wr && memwb.dest == idex.rs)            ex_a = memwb.val;
    if (exmem.vld && exmem.we && exmem.dest == idex.rt) ex_b = exmem.alu;
    else if (wb_wr && memwb.dest == idex.rt)            ex_b = memwb.val;
`endif
    ex_alu = '0;
    case (idex.op)
      OP_ADD:                   ex_alu = ex_a + ex_b;
      OP_SUB:                   ex_alu = ex_a - ex_b;
      OP_AND:                   ex_alu = ex_a & ex_b;
      OP_OR:                    ex_alu = ex_a | ex_b;
      OP_SLT:                   ex_alu[0] = ($signed(ex_a) < $signed(ex_b));
      OP_MUL:                   ex_alu = ex_a * ex_b;
      OP_LW, OP_SW, OP_ADDI:    ex_alu = ex_a + idex.imm;
      OP_SUBI:                  ex_alu = ex_a - idex.imm;
      OP_SLTI:                  ex_alu[0] = ($signed(ex_a) < $signed(idex.imm));
      default:                  ex_alu = '0;
    endcase
    br_taken  = idex.vld & (((idex.op == OP_BEQ) & (ex_a == ex_b)) |
                            ((idex.op == OP_BNE) & (ex_a != ex_b)));
    br_target = idex.pc + IAW'(1) + IAW'($signed(idex.imm[15:0]));
  end

  // Program-load port; only accepted while the core is not running.
  always_ff @(posedge clk) begin
    if (prog_we && !run) imem[prog_addr] <= prog_wdata;
  end

  // Data memory store in MEM; contents survive reset.
  always_ff @(posedge clk) begin
    if (exmem.vld && exmem.is_sw) dmem[exmem.alu[DAW-1:0]] <= exmem.sd;
  end

  // Fetch: redirect on taken branch, hold on stall, stop after HLT is decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ifid    <= '0;
      stopped <= 1'b0;
    end else begin
      if (hlt_id) stopped <= 1'b1;
      if (br_taken) begin
        pc       <= br_target;
        ifid.vld <= 1'b0;
      end else if (stall) begin
        pc   <= pc;
        ifid <= ifid;
      end else if (fetch_en && !hlt_id) begin
        ifid.vld <= 1'b1;
        ifid.pc  <= pc;
        ifid.ir  <= imem[pc];
        pc       <= pc + IAW'(1);
      end else begin
        ifid.vld <= 1'b0;
      end
    end
  end

  // ID/EX register; a stall or a taken branch injects a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex <= '0;
    end else if (br_taken || stall) begin
      idex.vld <= 1'b0;
      idex.we  <= 1'b0;
      idex.op  <= '0;
    end else begin
      idex.vld  <= ifid.vld;
      idex.op   <= id_op;
`ifdef MIPS_FWD_EN
      idex.rs   <= id_rs;
      idex.rt   <= id_rt;
`endif
      idex.dest <= id_dest;
      idex.we   <= id_we & ifid.vld;
      idex.a    <= id_a;
      idex.b    <= id_b;
      idex.imm  <= id_imm;
      idex.pc   <= ifid.pc;
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem <= '0;
    end else begin
      exmem.vld   <= idex.vld;
      exmem.we    <= idex.vld & idex.we;
      exmem.is_lw <= idex.op == OP_LW;
      exmem.is_sw <= idex.op == OP_SW;
      exmem.hlt   <= idex.op == OP_HLT;
      exmem.dest  <= idex.dest;
      exmem.alu   <= ex_alu;
      exmem.sd    <= ex_b;
    end
  end

  // MEM/WB register; loads pick up the memory word here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb <= '0;
    end else begin
      memwb.vld  <= exmem.vld;
      memwb.we   <= exmem.vld & exmem.we;
      memwb.hlt  <= exmem.vld & exmem.hlt;
      memwb.dest <= exmem.dest;
      memwb.val  <= exmem.is_lw ? lmd : exmem.alu;
    end
  end

  // Writeback commit: register write, retirement count and halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      retired   <= '0;
      halt_pend <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (wb_wr) regs[memwb.dest] <= memwb.val;
      if (memwb.vld) retired <= retired + 32'd1;
      halt_pend <= memwb.vld & memwb.hlt;
      if (halt_pend) halted <= 1'b1;
    end
  end

endmodule
